// File: rtl/ball_collision_ctrl.sv
// Ball motion and collision sequencer: one six-state pass per frame_tick.
// Optional feature macro BALL_SPEEDUP_EN: each paddle hit raises speed up to SPEED_MAX.
module ball_collision_ctrl #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int SPEED_INIT = 2,
    parameter int SPEED_MAX  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] padl_x,
    input  logic [8:0] padl_y,
    input  logic [9:0] padr_x,
    input  logic [8:0] padr_y,
    input  logic [9:0] pad_w,
    input  logic [8:0] pad_h,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       ball_dx,
    output logic       ball_dy,
    output logic       score_l,
    output logic       score_r,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WALL = 3'd1;
    localparam logic [2:0] S_PADL = 3'd2;
    localparam logic [2:0] S_PADR = 3'd3;
    localparam logic [2:0] S_EDGE = 3'd4;
    localparam logic [2:0] S_MOVE = 3'd5;

    // Speed register is sized for whichever of the two limits is larger.
    localparam int SPD_TOP = (SPEED_MAX > SPEED_INIT) ? SPEED_MAX : SPEED_INIT;
    localparam int SPD_W   = $clog2(SPD_TOP + 1);

    localparam logic [SPD_W-1:0] SPD_INIT = SPD_W'(SPEED_INIT);

    localparam logic [9:0]  X_HOME  = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [8:0]  Y_HOME  = 9'(SCREEN_H / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  BALL_X  = 10'(BALL_SIZE);
    localparam logic [8:0]  BALL_Y  = 9'(BALL_SIZE);
    localparam logic [10:0] BALL_XW = 11'(BALL_SIZE);
    localparam logic [9:0]  BALL_YW = 10'(BALL_SIZE);
    localparam logic [10:0] EXT_W   = 11'(SCREEN_W);
    localparam logic [9:0]  EXT_H   = 10'(SCREEN_H);

    logic [2:0]       state;
    logic             hit;
    logic             goal_l;
    logic             goal_r;
    logic [SPD_W-1:0] speed;
    logic [SPD_W-1:0] speed_hit;

    logic [10:0] spd_xw;
    logic [9:0]  spd_yw;
    logic [10:0] x_far;
    logic [9:0]  y_far;
    logic        top_bounce;
    logic        bot_bounce;
    logic        edge_l;
    logic        edge_r;
    logic        over_l;
    logic        over_r;
    logic [9:0]  step_x;
    logic [8:0]  step_y;
    logic [9:0]  next_x;
    logic [8:0]  next_y;

    // Inclusive box overlap, widened by one bit so the sums cannot wrap.
    function automatic logic box_hit(
        input logic [9:0] ax,
        input logic [8:0] ay,
        input logic [9:0] aw,
        input logic [8:0] ah,
        input logic [9:0] bx,
        input logic [8:0] by,
        input logic [9:0] bw,
        input logic [8:0] bh
    );
        logic x_ok;
        logic y_ok;
        x_ok = ({1'b0, ax} <= {1'b0, bx} + {1'b0, bw})
            && ({1'b0, bx} <= {1'b0, ax} + {1'b0, aw});
        y_ok = ({1'b0, ay} <= {1'b0, by} + {1'b0, bh})
            && ({1'b0, by} <= {1'b0, ay} + {1'b0, ah});
        return x_ok && y_ok;
    endfunction

    always_comb begin
        spd_xw = 11'(speed);
        spd_yw = 10'(speed);
        x_far  = {1'b0, ball_x} + BALL_XW + spd_xw;
        y_far  = {1'b0, ball_y} + BALL_YW + spd_yw;

        top_bounce = ball_dy && ({1'b0, ball_y} < spd_yw);
        bot_bounce = !ball_dy && (y_far >= EXT_H);

        // Ball leaving on the left is a point for the right player.
        edge_r = ball_dx && ({1'b0, ball_x} < spd_xw);
        edge_l = !ball_dx && (x_far >= EXT_W);

        over_l = box_hit(ball_x, ball_y, BALL_X, BALL_Y,
                         padl_x, padl_y, pad_w, pad_h);
        over_r = box_hit(ball_x, ball_y, BALL_X, BALL_Y,
                         padr_x, padr_y, pad_w, pad_h);

        step_x = 10'(speed);
        step_y = 9'(speed);
        next_x = ball_dx ? ball_x - step_x : ball_x + step_x;
        next_y = ball_dy ? ball_y - step_y : ball_y + step_y;
    end

`ifdef BALL_SPEEDUP_EN
    localparam logic [SPD_W-1:0] SPD_CAP = SPD_W'(SPEED_MAX);
    localparam logic [SPD_W-1:0] SPD_ONE = SPD_W'(1);

    always_comb begin
        speed_hit = (speed < SPD_CAP) ? speed + SPD_ONE : speed;
    end
`else
    always_comb begin
        speed_hit = speed;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ball_x  <= X_HOME;
            ball_y  <= Y_HOME;
            ball_dx <= 1'b0;
            ball_dy <= 1'b0;
            speed   <= SPD_INIT;
            hit     <= 1'b0;
            goal_l  <= 1'b0;
            goal_r  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        state  <= S_WALL;
                        hit    <= 1'b0;
                        goal_l <= 1'b0;
                        goal_r <= 1'b0;
                    end
                end
                S_WALL: begin
                    if (top_bounce) begin
                        ball_dy <= 1'b0;
                    end else if (bot_bounce) begin
                        ball_dy <= 1'b1;
                    end
                    state <= S_PADL;
                end
                S_PADL: begin
                    if (ball_dx && over_l) begin
                        ball_dx <= 1'b0;
                        hit     <= 1'b1;
                        speed   <= speed_hit;
                    end
                    state <= S_PADR;
                end
                S_PADR: begin
                    if (!ball_dx && over_r) begin
                        ball_dx <= 1'b1;
                        hit     <= 1'b1;
                        speed   <= speed_hit;
                    end
                    state <= S_EDGE;
                end
                S_EDGE: begin
                    // A paddle save this frame overrides any score.
                    if (!hit) begin
                        goal_l <= edge_l;
                        goal_r <= edge_r;
                    end
                    state <= S_MOVE;
                end
                S_MOVE: begin
                    if (goal_l || goal_r) begin
                        ball_x  <= X_HOME;
                        ball_y  <= Y_HOME;
                        ball_dx <= !ball_dx;
                        speed   <= SPD_INIT;
                    end else begin
                        ball_x <= next_x;
                        ball_y <= next_y;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign score_l = (state == S_MOVE) && goal_l;
    assign score_r = (state == S_MOVE) && goal_r;

endmodule

// File: tb/tb_ball_collision_ctrl.sv
// Scoreboard bench for ball_collision_ctrl: a reference model queues the
// expected end-of-frame state at each tick, compared when done pulses.
module tb_ball_collision_ctrl;

    localparam int SW    = 640;
    localparam int SH    = 480;
    localparam int BS    = 8;
    localparam int SP0   = 2;
    localparam int SPMAX = 6;
    localparam int HX    = SW / 2 - BS / 2;
    localparam int HY    = SH / 2 - BS / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [9:0] padl_x;
    logic [8:0] padl_y;
    logic [9:0] padr_x;
    logic [8:0] padr_y;
    logic [9:0] pad_w;
    logic [8:0] pad_h;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       ball_dx;
    logic       ball_dy;
    logic       score_l;
    logic       score_r;
    logic       busy;
    logic       done;

    ball_collision_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .padl_x     (padl_x),
        .padl_y     (padl_y),
        .padr_x     (padr_x),
        .padr_y     (padr_y),
        .pad_w      (pad_w),
        .pad_h      (pad_h),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_dx    (ball_dx),
        .ball_dy    (ball_dy),
        .score_l    (score_l),
        .score_r    (score_r),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int dx;
        int dy;
        int sl;
        int sr;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int m_x;
    int m_y;
    int m_dx;
    int m_dy;
    int m_spd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ovl(int ax, int ay, int aw, int ah,
                               int bx, int by, int bw, int bh);
        return (ax <= bx + bw) && (bx <= ax + aw)
            && (ay <= by + bh) && (by <= ay + ah);
    endfunction

    function automatic int clamp9(int v);
        return (v < 0) ? 0 : ((v > 511) ? 511 : v);
    endfunction

    task automatic model_reset();
        m_x   = HX;
        m_y   = HY;
        m_dx  = 0;
        m_dy  = 0;
        m_spd = SP0;
    endtask

    task automatic model_frame();
        exp_t e;
        bit hit = 0;
        bit sl  = 0;
        bit sr  = 0;
        if (m_dy == 1 && m_y < m_spd) m_dy = 0;
        else if (m_dy == 0 && m_y + BS + m_spd >= SH) m_dy = 1;
        if (m_dx == 1 && ovl(m_x, m_y, BS, BS, int'(padl_x), int'(padl_y),
                             int'(pad_w), int'(pad_h))) begin
            m_dx = 0;
            hit  = 1;
`ifdef BALL_SPEEDUP_EN
            if (m_spd < SPMAX) m_spd++;
`endif
        end
        if (m_dx == 0 && ovl(m_x, m_y, BS, BS, int'(padr_x), int'(padr_y),
                             int'(pad_w), int'(pad_h))) begin
            m_dx = 1;
            hit  = 1;
`ifdef BALL_SPEEDUP_EN
            if (m_spd < SPMAX) m_spd++;
`endif
        end
        if (!hit) begin
            if (m_dx == 1 && m_x < m_spd) sr = 1;
            else if (m_dx == 0 && m_x + BS + m_spd >= SW) sl = 1;
        end
        if (sl || sr) begin
            m_x   = HX;
            m_y   = HY;
            m_dx  = 1 - m_dx;
            m_spd = SP0;
        end else begin
            m_x = (m_dx == 1) ? m_x - m_spd : m_x + m_spd;
            m_y = (m_dy == 1) ? m_y - m_spd : m_y + m_spd;
        end
        e.x  = m_x;
        e.y  = m_y;
        e.dx = m_dx;
        e.dy = m_dy;
        e.sl = int'(sl);
        e.sr = int'(sr);
        sb.push_back(e);
    endtask

    task automatic park_paddles();
        padl_x = 10'd16;
        padl_y = 9'd500;
        padr_x = 10'd616;
        padr_y = 9'd500;
        pad_w  = 10'd8;
        pad_h  = 9'd4;
    endtask

    task automatic set_paddles(input int mode);
        if (mode == 0) begin
            park_paddles();
        end else begin
            padl_x = 10'($urandom_range(14, 18));
            padr_x = 10'($urandom_range(612, 618));
            pad_w  = 10'($urandom_range(4, 12));
            pad_h  = 9'd64;
            if (mode == 1) begin
                padl_y = 9'(clamp9(m_y - int'($urandom_range(0, 56))));
                padr_y = 9'(clamp9(m_y - int'($urandom_range(0, 56))));
            end else if (mode == 2) begin
                padl_y = 9'(clamp9(m_y + BS + 1));
                padr_y = 9'(m_y >= 65 ? m_y - 65 : 500);
            end else begin
                padl_y = 9'(clamp9(m_y + BS));
                padr_y = 9'(clamp9(m_y - 64));
            end
        end
    endtask

    task automatic run_frame(input bit retick);
        exp_t e;
        int lat    = 0;
        int busy_n = 0;
        int sl_n   = 0;
        int sr_n   = 0;
        int sl_at  = 0;
        int sr_at  = 0;
        model_frame();
        frame_tick = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            frame_tick = retick && (n == 2);
            if (busy) busy_n++;
            if (score_l) begin
                sl_n++;
                sl_at = n;
            end
            if (score_r) begin
                sr_n++;
                sr_at = n;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        frame_tick = 1'b0;
        check("done_latency", lat, 6);
        check("busy_cycles", busy_n, 5);
        e = sb.pop_front();
        check("ball_x", ball_x, e.x);
        check("ball_y", ball_y, e.y);
        check("ball_dx", ball_dx, e.dx);
        check("ball_dy", ball_dy, e.dy);
        check("score_l_pulses", sl_n, e.sl);
        check("score_r_pulses", sr_n, e.sr);
        if (e.sl != 0) check("score_l_cycle", sl_at, 5);
        if (e.sr != 0) check("score_r_cycle", sr_at, 5);
        @(posedge clk);
        #1;
        check("idle_after_done", busy, 0);
        check("done_single", done, 0);
    endtask

    task automatic reset_mid_frame();
        int stray = 0;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("in_padr_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ball_x", ball_x, HX);
        check("rst_ball_y", ball_y, HY);
        check("rst_dx", ball_dx, 0);
        check("rst_dy", ball_dy, 0);
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done || busy || score_l || score_r) stray++;
        end
        check("rst_no_done", stray, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        park_paddles();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("init_ball_x", ball_x, HX);
        check("init_ball_y", ball_y, HY);
        check("init_dx", ball_dx, 0);
        check("init_dy", ball_dy, 0);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_score_l", score_l, 0);
        check("init_score_r", score_r, 0);

        // Free flight from home, then a frame with a second tick in PADL.
        run_frame(1'b0);
        check("free_x", ball_x, 318);
        check("free_y", ball_y, 238);
        run_frame(1'b1);

        for (int f = 0; f < 520; f++) begin
            set_paddles(int'($urandom_range(0, 3)));
            run_frame((f % 97) == 50);
        end

        reset_mid_frame();

        for (int f = 0; f < 40; f++) begin
            set_paddles(int'($urandom_range(0, 3)));
            run_frame(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
